flp_rndpack: RTL and testbench
==============================

// Module: flp_rndpack
// PURPOSE
//  Round-and-pack stage directly downstream of the shift-right-and-jam aligner in the FP datapath.
//  Takes a normalised, jammed mantissa with round and sticky bits, a sign and a wide signed biased exponent.
//  Applies round-to-nearest-even, renormalises, saturates and flushes, and emits a packed IEEE-754 binary32 word.
//  2-stage pipeline with valid/ready handshake on both sides.
// PARAMETERS
//  EWIDTH  10  signed biased exponent width on input (two's complement, bias 127); must be >= 9
//  MWIDTH  26  input mantissa width, fixed layout: [25] hidden 1, [24:2] fraction, [1] round (G), [0] sticky (S)
// PORTS
//  clk        in   1       clock; all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       input operand valid
//  in_ready   out  1       stage can accept; transfer when in_valid & in_ready
//  in_sign    in   1       sign of result
//  in_exp     in   EWIDTH  signed biased exponent of in_mant
//  in_mant    in   MWIDTH  jammed mantissa; in_mant[25]==0 means exact zero operand
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts; transfer when out_valid & out_ready
//  out_data   out  32      packed binary32 {sign, exp[7:0], frac[22:0]}
//  out_flags  out  4       {ovf, unf, inexact, zero}
// BEHAVIOUR
//  Reset: s1_valid=0, out_valid=0, out_data=0, out_flags=0; any in-flight operands are discarded; no partial output.
//  Advance: s2_en = ~out_valid | out_ready; s1_en = ~s1_valid | s2_en; in_ready = s1_en (combinational from out_ready).
//  S1 (on s1_en): s1_valid<=in_valid. When in_valid, register sign, exp, zero=~in_mant[25],
//   grs = in_mant[1] | in_mant[0], rnd_up = in_mant[1] & (in_mant[0] | in_mant[2]),
//   sum[24:0] = {1'b0, in_mant[25:2]} + rnd_up.
//  S2 (on s2_en): out_valid<=s1_valid. When s1_valid:
//   carry=sum[24]; frac = carry ? sum[23:1] : sum[22:0]; e = exp + carry (EWIDTH+1 bits, signed).
//   zero operand: out_data={sign,31'h0}; flags {0,0,0,1}; grs ignored.
//   e >= 255: out_data={sign,8'hFF,23'h0} (inf); flags {1,0,1,0}.
//   e <= 0: flush to {sign,31'h0}; flags {0,1,1,0} (no subnormals produced).
//   else: out_data={sign,e[7:0],frac}; flags {0,0,grs,0}.
//  Priority: zero > ovf > unf > normal. Only one of ovf/unf/zero is ever set.
//  Latency: 2 cycles from accepted input to out_valid when out_ready held 1; throughput 1/cycle.
//  Backpressure: out_ready=0 with out_valid=1 holds out_data/out_flags stable; S1 still fills if empty;
//   with both stages full in_ready=0. No loss, no duplication, order preserved.
//  Simultaneous accept at both ends: S2 reloads from S1 and S1 reloads from input in the same cycle.
//  out_valid never drops without a transfer except via rst.
// STRUCTURE
//  Shared include flp_defs.vh: FP32_BIAS=127, FP32_EMAX=8'hFE, FP32_EINF=8'hFF, FP32_FRACW=23,
//   flag bit indices FLG_OVF=3, FLG_UNF=2, FLG_INX=1, FLG_ZERO=0.
//  One combinational sub-module flp_rne_inc: (lsb, g, s) -> rnd_up; reused by later FP stages.
//  Pipeline registers and handshake logic stay in this module.
// TESTING
//  1.0: sign=0 exp=127 mant=26'h2000000 -> out_data=32'h3F800000, flags=4'b0000, out_valid 2 cycles later.
//  Tie to even: mant={1'b1,23'h000001,2'b10}, exp=127 -> 32'h3F800002 inexact; {1'b1,23'h0,2'b10} -> 32'h3F800000 inexact.
//  Carry: mant={1'b1,23'h7FFFFF,2'b11}, exp=127 -> 32'h40000000, flags=4'b0010; same with exp=254 -> 32'h7F800000, flags=4'b1010.
//  Underflow/zero: exp=0 sign=1 mant=26'h2000000 -> 32'h80000000 flags=4'b0110; mant=0 exp=-5 -> 32'h00000000 flags=4'b0001.
//  Backpressure: stream 5 operands, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted, out_data stable, all 5 out in order.
//  Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, out_data=0, in_ready=1; no stale result emitted.

Source files
------------

// File: rtl/flp_rndpack_pkg.sv
// Shared constants and types for the binary32 round-and-pack stage.
// Also holds the exponent limits and flag bit positions reused by later FP stages.
package flp_rndpack_pkg;

    localparam int          FP32_BIAS  = 127;
    localparam logic [7:0]  FP32_EMAX  = 8'hFE;
    localparam logic [7:0]  FP32_EINF  = 8'hFF;
    localparam int          FP32_FRACW = 23;

    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] data;
    } rp_result_t;

endpackage

// File: rtl/flp_rne_inc.sv
// Round-to-nearest-even increment decision from the kept LSB, guard and sticky bits.
module flp_rne_inc (
    input  logic i_lsb,
    input  logic i_g,
    input  logic i_s,
    output logic o_rnd_up
);

    // Exact ties (g=1, s=0) round up only when that makes the LSB even.
    assign o_rnd_up = i_g & (i_s | i_lsb);

endmodule

// File: rtl/flp_rndpack.sv
// Two-stage round-and-pack: RNE increment in stage 1, renormalise/saturate/flush/pack in stage 2.
// Both stages advance under a valid/ready handshake; in_ready depends combinationally on out_ready.
module flp_rndpack
    import flp_rndpack_pkg::*;
#(
    parameter int EWIDTH = 10,
    parameter int MWIDTH = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic signed [EWIDTH-1:0] in_exp,
    input  logic        [MWIDTH-1:0] in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [31:0]       out_data,
    output logic        [3:0]        out_flags
);

    localparam logic signed [EWIDTH:0] E_MAX  = $signed((EWIDTH+1)'(FP32_EMAX));
    localparam logic signed [EWIDTH:0] E_ZERO = '0;

    function automatic rp_result_t pack_result(
        input logic                     sign,
        input logic                     zero,
        input logic                     grs,
        input logic signed [EWIDTH:0]   e,
        input logic [FP32_FRACW-1:0]    frac
    );
        rp_result_t r;
        r.flags = '0;
        r.data  = {sign, 31'h0};
        if (zero) begin
            r.flags[FLG_ZERO] = 1'b1;
        end else if (e > E_MAX) begin
            r.data           = {sign, FP32_EINF, {FP32_FRACW{1'b0}}};
            r.flags[FLG_OVF] = 1'b1;
            r.flags[FLG_INX] = 1'b1;
        end else if (e <= E_ZERO) begin
            r.flags[FLG_UNF] = 1'b1;
            r.flags[FLG_INX] = 1'b1;
        end else begin
            r.data           = {sign, e[7:0], frac};
            r.flags[FLG_INX] = grs;
        end
        return r;
    endfunction

    logic                     w_s2_en;
    logic                     w_s1_en;
    logic                     w_rnd_up;
    logic                     w_carry;
    logic [FP32_FRACW-1:0]    w_frac;
    logic signed [EWIDTH:0]   w_e;
    rp_result_t               w_res;

    logic                     r_vld_p1;
    logic                     r_sign_p1;
    logic signed [EWIDTH-1:0] r_exp_p1;
    logic                     r_zero_p1;
    logic                     r_grs_p1;
    logic [24:0]              r_sum_p1;

    logic                     r_vld_p2;
    logic [31:0]              r_data_p2;
    logic [3:0]               r_flags_p2;

    assign w_s2_en  = ~r_vld_p2 | out_ready;
    assign w_s1_en  = ~r_vld_p1 | w_s2_en;
    assign in_ready = w_s1_en;

    flp_rne_inc u_rne (
        .i_lsb   (in_mant[2]),
        .i_g     (in_mant[1]),
        .i_s     (in_mant[0]),
        .o_rnd_up(w_rnd_up)
    );

    // Stage 1: round increment on the 24-bit significand, carry kept in bit 24.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_en) begin
            r_vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_en && in_valid) begin
            r_sign_p1 <= in_sign;
            r_exp_p1  <= in_exp;
            r_zero_p1 <= ~in_mant[25];
            r_grs_p1  <= in_mant[1] | in_mant[0];
            r_sum_p1  <= {1'b0, in_mant[25:2]} + 25'(w_rnd_up);
        end
    end

    // Stage 2: renormalise on carry-out, then classify and pack.
    assign w_carry = r_sum_p1[24];
    assign w_frac  = w_carry ? r_sum_p1[23:1] : r_sum_p1[22:0];
    assign w_e     = $signed({r_exp_p1[EWIDTH-1], r_exp_p1}) + $signed({{EWIDTH{1'b0}}, w_carry});
    assign w_res   = pack_result(r_sign_p1, r_zero_p1, r_grs_p1, w_e, w_frac);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2   <= 1'b0;
            r_data_p2  <= '0;
            r_flags_p2 <= '0;
        end else if (w_s2_en) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2  <= w_res.data;
                r_flags_p2 <= w_res.flags;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_flags = r_flags_p2;

endmodule

// File: tb/tb_flp_rndpack.sv
// Directed bench for flp_rndpack: rounding, saturation, flush, zero, backpressure, reset mid-stream.
module tb_flp_rndpack;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic signed [9:0] in_exp;
    logic [25:0]       in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [3:0]        out_flags;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic              s;
        logic signed [9:0] e;
        logic [25:0]       m;
        logic [31:0]       d;
        logic [3:0]        f;
    } vec_t;

    flp_rndpack #(.EWIDTH(10), .MWIDTH(26)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_exp   (in_exp),
        .in_mant  (in_mant),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic s, input logic signed [9:0] e, input logic [25:0] m,
                          output logic [31:0] d, output logic [3:0] f, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = out_data;
        f = out_flags;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset: valid=%b data=%h flags=%b ready=%b, want 0 00000000 0000 1",
                     out_valid, out_data, out_flags, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_one();
        logic [31:0] d; logic [3:0] f; int lat;
        run_op(1'b0, 10'sd127, 26'h2000000, d, f, lat);
        nchk++;
        if (lat !== 2) begin
            nerr++; $display("FAIL one_latency: got %0d cycles, want 2", lat);
        end
        nchk++;
        if (d !== 32'h3F800000 || f !== 4'b0000) begin
            nerr++; $display("FAIL one_value: got %h/%b, want 3f800000/0000", d, f);
        end
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL one_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_vectors();
        vec_t v[12];
        logic [31:0] d; logic [3:0] f; int lat;
        v[0]  = '{1'b0, 10'sd127, {1'b1, 23'h000001, 2'b10}, 32'h3F800002, 4'b0010};
        v[1]  = '{1'b0, 10'sd127, {1'b1, 23'h000000, 2'b10}, 32'h3F800000, 4'b0010};
        v[2]  = '{1'b0, 10'sd127, {1'b1, 23'h7FFFFF, 2'b11}, 32'h40000000, 4'b0010};
        v[3]  = '{1'b0, 10'sd254, {1'b1, 23'h7FFFFF, 2'b11}, 32'h7F800000, 4'b1010};
        v[4]  = '{1'b1, 10'sd0,   26'h2000000,               32'h80000000, 4'b0110};
        v[5]  = '{1'b0, -10'sd5,  26'h0000000,               32'h00000000, 4'b0001};
        v[6]  = '{1'b1, 10'sd128, 26'h2000000,               32'hC0000000, 4'b0000};
        v[7]  = '{1'b0, 10'sd254, 26'h2000000,               32'h7F000000, 4'b0000};
        v[8]  = '{1'b1, 10'sd300, 26'h2000000,               32'hFF800000, 4'b1010};
        v[9]  = '{1'b0, 10'sd1,   {1'b1, 23'h7FFFFF, 2'b01}, 32'h00FFFFFF, 4'b0010};
        v[10] = '{1'b0, -10'sd1,  {1'b1, 23'h7FFFFF, 2'b11}, 32'h00000000, 4'b0110};
        v[11] = '{1'b1, 10'sd300, 26'h0000003,               32'h80000000, 4'b0001};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].s, v[i].e, v[i].m, d, f, lat);
            nchk++;
            if (lat !== 2 || d !== v[i].d || f !== v[i].f) begin
                nerr++;
                $display("FAIL vec%0d: got %h/%b lat %0d, want %h/%b lat 2", i, d, f, lat, v[i].d, v[i].f);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        logic [31:0] held = '0;
        logic have_held = 1'b0;
        logic [31:0] want;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (sent < 5);
            in_sign   = 1'b0;
            in_exp    = 10'(127 + sent);
            in_mant   = 26'h2000000;
            #1;
            if (cyc == 3) begin
                nchk++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    nerr++; $display("FAIL bp_full: in_ready=%b accepted=%0d, want 0 and 2", in_ready, sent);
                end
            end
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    nchk++;
                    if (out_data !== held) begin
                        nerr++; $display("FAIL bp_stable: got %h, want %h", out_data, held);
                    end
                end
                held = out_data;
                have_held = 1'b1;
            end
            if (out_valid && out_ready) begin
                want = {1'b0, 8'(127 + got), 23'h0};
                nchk++;
                if (out_data !== want || out_flags !== 4'b0000) begin
                    nerr++; $display("FAIL bp_order%0d: got %h/%b, want %h/0000", got, out_data, out_flags, want);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        nchk++;
        if (got != 5) begin
            nerr++; $display("FAIL bp_count: got %0d results, want 5", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0;
        logic [31:0] want;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 6);
            in_sign   = sent[0];
            in_exp    = 10'(100 + sent);
            in_mant   = {1'b1, 23'(sent), 2'b00};
            #1;
            if (in_valid) begin
                nchk++;
                if (in_ready !== 1'b1) begin
                    nerr++; $display("FAIL b2b_ready%0d: in_ready=%b, want 1", cyc, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                want = {got[0], 8'(100 + got), 23'(got)};
                nchk++;
                if (out_data !== want || out_flags !== 4'b0000) begin
                    nerr++; $display("FAIL b2b_data%0d: got %h/%b, want %h/0000", got, out_data, out_flags, want);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        nchk++;
        if (got != 6) begin
            nerr++; $display("FAIL b2b_count: got %0d results in 8 cycles, want 6", got);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sign = 1'b1; in_exp = 10'sd130; in_mant = 26'h2000000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        nchk++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_full: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid: valid=%b data=%h flags=%b ready=%b, want 0 00000000 0000 1",
                     out_valid, out_data, out_flags, in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        nchk++;
        if (seen != 0) begin
            nerr++; $display("FAIL rst_stale: %0d stale results emitted, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_one();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
